crop_border: RTL and testbench

Streaming border-removal (crop) block for the convolution datapath. It takes a raster-order frame of (D+2P)×(D+2P) pixels, such as a zero-padded frame or a "same"-size convolution result, and forwards only the inner D×D pixels. Output is registered and carries line/frame markers. The block sits at the output end of a padded convolution stage, inverting the padding step so that downstream stages see the original D×D geometry.

---
 rtl/crop_border.sv | 108 ++++++++++
 tb/tb_crop_border.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/crop_border.sv
// Streaming crop: forwards the inner D x D pixels of an (D+2P) x (D+2P) raster frame.
// Outputs are registered (1-cycle latency) and carry end-of-line / end-of-frame markers.
module crop_border #(
  parameter int D          = 220,
  parameter int P          = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  sof,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  out_valid,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic                  frame_done,
  output logic                  sync_err
);

  localparam int N  = D + 2 * P;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [CW-1:0] C_LO   = CW'(P);
  localparam logic [CW-1:0] C_HI   = CW'(D + P - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_col, r_row;
  logic [CW-1:0]   w_col_nxt, w_row_nxt;
  logic [CW-1:0]   w_cur_col, w_cur_row;
  logic            w_accept, w_keep, w_eol, w_eof, w_done, w_err;

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_cur_col   = '0;
    w_cur_row   = '0;
    w_accept    = 1'b0;
    w_keep      = 1'b0;
    w_eol       = 1'b0;
    w_eof       = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;

    // A sof pixel always restarts at (0,0); in STREAM it also flags the aborted frame.
    if (in_valid) begin
      if (sof) begin
        w_accept = 1'b1;
        w_err    = (r_state == S_STREAM);
      end else if (r_state == S_STREAM) begin
        w_accept  = 1'b1;
        w_cur_col = r_col;
        w_cur_row = r_row;
      end else begin
        w_err = 1'b1;
      end
    end

    if (w_accept) begin
      w_keep      = (w_cur_row >= C_LO) && (w_cur_row <= C_HI) &&
                    (w_cur_col >= C_LO) && (w_cur_col <= C_HI);
      w_eol       = w_keep && (w_cur_col == C_HI);
      w_eof       = w_eol && (w_cur_row == C_HI);
      w_state_nxt = S_STREAM;
      if (w_cur_col == C_LAST) begin
        w_col_nxt = '0;
        if (w_cur_row == C_LAST) begin
          w_row_nxt   = '0;
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_row_nxt = w_cur_row + 1'b1;
        end
      end else begin
        w_col_nxt = w_cur_col + 1'b1;
        w_row_nxt = w_cur_row;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_row      <= '0;
      pxl_out    <= '0;
      out_valid  <= 1'b0;
      out_eol    <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      out_valid  <= w_keep;
      out_eol    <= w_eol;
      out_eof    <= w_eof;
      frame_done <= w_done;
      sync_err   <= w_err;
      if (w_keep) pxl_out <= pxl_in;
    end
  end

endmodule

// File: tb/tb_crop_border.sv
// Directed bench for crop_border: D=4/P=1 and D=4/P=2 instances share one input stream.
// A negedge monitor collects outputs; the initial block checks them against hand-built lists.
module tb_crop_border;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, sof;
  logic [31:0] pxl_in;

  logic [31:0] o1_pxl, o2_pxl;
  logic        o1_valid, o1_eol, o1_eof, o1_fd, o1_se;
  logic        o2_valid, o2_eol, o2_eof, o2_fd, o2_se;

  always #5 clk = ~clk;

  crop_border #(.D(4), .P(1), .DATA_WIDTH(32)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sof(sof), .pxl_in(pxl_in),
    .pxl_out(o1_pxl), .out_valid(o1_valid), .out_eol(o1_eol), .out_eof(o1_eof),
    .frame_done(o1_fd), .sync_err(o1_se));

  crop_border #(.D(4), .P(2), .DATA_WIDTH(32)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sof(sof), .pxl_in(pxl_in),
    .pxl_out(o2_pxl), .out_valid(o2_valid), .out_eol(o2_eol), .out_eof(o2_eof),
    .frame_done(o2_fd), .sync_err(o2_se));

  int n_tests = 0;
  int n_fail  = 0;

  // monitor state
  logic        p_valid;
  logic [31:0] p_pxl;
  logic [33:0] m1[$], m2[$], ex[$];
  int fd1, se1, fd2, se2, lat1, lat2, mk1, mk2;
  logic [31:0] fdp1, fdp2;

  always @(posedge clk) begin
    p_valid <= in_valid;
    p_pxl   <= pxl_in;
  end

  always @(negedge clk) begin
    if (o1_valid) begin
      m1.push_back({o1_eof, o1_eol, o1_pxl});
      if (!p_valid || p_pxl !== o1_pxl) lat1++;
    end
    if ((o1_eol && !o1_valid) || (o1_eof && !o1_eol)) mk1++;
    if (o1_fd) begin fd1++; fdp1 = p_pxl; end
    if (o1_se) se1++;
    if (o2_valid) begin
      m2.push_back({o2_eof, o2_eol, o2_pxl});
      if (!p_valid || p_pxl !== o2_pxl) lat2++;
    end
    if ((o2_eol && !o2_valid) || (o2_eof && !o2_eol)) mk2++;
    if (o2_fd) begin fd2++; fdp2 = p_pxl; end
    if (o2_se) se2++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    m1.delete(); m2.delete(); ex.delete();
    fd1 = 0; se1 = 0; fd2 = 0; se2 = 0;
    lat1 = 0; lat2 = 0; mk1 = 0; mk2 = 0;
    fdp1 = '1; fdp2 = '1;
  endtask

  task automatic px(input int v, input bit s);
    @(posedge clk); #2;
    in_valid = 1'b1; sof = s; pxl_in = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      in_valid = 1'b0; sof = 1'b0;
    end
  endtask

  task automatic frame(input int base, input int n, input bit tog);
    for (int i = 0; i < n; i++) begin
      px(base + i, i == 0);
      if (tog) idle(1);
    end
  endtask

  // Expected kept pixels of a frame whose pixel (r,c) carries base + r*n + c.
  task automatic exp_frame(input int base, input int n, input int p, input int d);
    for (int r = p; r < p + d; r++)
      for (int c = p; c < p + d; c++)
        ex.push_back({1'(r == p + d - 1 && c == p + d - 1), 1'(c == p + d - 1),
                      32'(base + r * n + c)});
  endtask

  task automatic cmp_q(input string tag, input bit use2);
    logic [33:0] q[$];
    q = use2 ? m2 : m1;
    chk({tag, " count"}, q.size(), ex.size());
    for (int i = 0; i < q.size() && i < ex.size(); i++)
      chk($sformatf("%s item%0d", tag, i), q[i], ex[i]);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; sof = 1'b0; pxl_in = '0;
    clr();
    #1;
    chk("rst out_valid", o1_valid, 1'b0);
    chk("rst pxl_out",   o1_pxl,   32'd0);
    chk("rst flags", {o1_eol, o1_eof, o1_fd, o1_se}, 4'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // contiguous D=4,P=1 frame
    clr();
    frame(0, 36, 1'b0); idle(4);
    exp_frame(0, 6, 1, 4);
    cmp_q("s1", 1'b0);
    chk("s1 frame_done", fd1, 1);
    chk("s1 fd after px", fdp1, 35);
    chk("s1 sync_err", se1, 0);
    chk("s1 latency", lat1, 0);
    chk("s1 markers", mk1, 0);

    // same frame with gaps every other cycle
    clr();
    frame(0, 36, 1'b1); idle(4);
    exp_frame(0, 6, 1, 4);
    cmp_q("s2", 1'b0);
    chk("s2 frame_done", fd1, 1);
    chk("s2 fd after px", fdp1, 35);
    chk("s2 sync_err", se1, 0);
    chk("s2 latency", lat1, 0);

    // resync after 20 pixels
    clr();
    frame(0, 20, 1'b0);
    px(100, 1'b1);
    for (int i = 1; i < 36; i++) px(100 + i, 1'b0);
    idle(4);
    ex.push_back({2'b00, 32'd7});  ex.push_back({2'b00, 32'd8});
    ex.push_back({2'b00, 32'd9});  ex.push_back({2'b01, 32'd10});
    ex.push_back({2'b00, 32'd13}); ex.push_back({2'b00, 32'd14});
    ex.push_back({2'b00, 32'd15}); ex.push_back({2'b01, 32'd16});
    ex.push_back({2'b00, 32'd19});
    exp_frame(100, 6, 1, 4);
    cmp_q("s3", 1'b0);
    chk("s3 sync_err", se1, 1);
    chk("s3 frame_done", fd1, 1);
    chk("s3 fd after px", fdp1, 135);

    // async reset mid-frame after pixel 15 (a kept position)
    clr();
    frame(0, 16, 1'b0);
    @(posedge clk); #3;
    reset = 1'b1; in_valid = 1'b0; sof = 1'b0;
    #1;
    chk("s4 rst out_valid", o1_valid, 1'b0);
    chk("s4 rst pxl_out", o1_pxl, 32'd0);
    chk("s4 rst flags", {o1_eol, o1_eof, o1_fd, o1_se}, 4'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    clr();
    px(50, 1'b0); px(51, 1'b0); px(52, 1'b0); idle(3);
    chk("s4 dropped sync_err", se1, 3);
    chk("s4 dropped out_valid", m1.size(), 0);
    chk("s4 dropped frame_done", fd1, 0);
    clr();
    frame(0, 36, 1'b0); idle(4);
    exp_frame(0, 6, 1, 4);
    cmp_q("s4 frame", 1'b0);
    chk("s4 frame_done", fd1, 1);
    chk("s4 sync_err", se1, 0);

    // back-to-back frames
    clr();
    frame(0, 36, 1'b0);
    frame(0, 36, 1'b0);
    idle(4);
    exp_frame(0, 6, 1, 4);
    exp_frame(0, 6, 1, 4);
    cmp_q("s6", 1'b0);
    chk("s6 frame_done", fd1, 2);
    chk("s6 sync_err", se1, 0);
    chk("s6 latency", lat1, 0);

    // D=4,P=2 on the second instance
    @(posedge clk); #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    clr();
    frame(0, 64, 1'b0); idle(4);
    exp_frame(0, 8, 2, 4);
    cmp_q("s5", 1'b1);
    chk("s5 frame_done", fd2, 1);
    chk("s5 fd after px", fdp2, 63);
    chk("s5 sync_err", se2, 0);
    chk("s5 latency", lat2, 0);
    chk("s5 markers", mk2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
